tag_comparator: RTL and testbench
=================================

Name: tag_comparator

Overview:
- Cache tag-match block: compares the request tag against the stored tag of each way and qualifies the result with the way's valid bit to produce hit/miss.
- Sits between the cache tag/valid arrays and the cache controller FSM; its hit output steers IDLE -> MEM_READ transitions and busywait release.
- Combinational match/hit path, plus a registered copy of the result and optional hit/miss statistics.

Parameters:
- TAG_WIDTH, 3, width of each tag in bits.
- WAYS, 1, number of ways compared in parallel.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- compare_en  input  1  lookup strobe; qualifies registered capture and statistics.
- req_tag  input  TAG_WIDTH  tag field of the current address.
- stored_tags  input  WAYS*TAG_WIDTH  stored tag per way; way w at [w*TAG_WIDTH +: TAG_WIDTH].
- stored_valid  input  WAYS  valid bit per way.
- match  output  1  combinational: 1 when any way's tag equals req_tag, ignoring valid.
- way_match  output  WAYS  combinational per-way tag equality, ignoring valid.
- hit  output  1  combinational: OR over w of (way_match[w] & stored_valid[w]).
- hit_way  output  WAYS  one-hot hitting way; lowest index wins if several hit; all zero on miss.
- hit_idx  output  max(1,clog2(WAYS))  binary index of hit_way; 0 on miss.
- multi_hit  output  1  combinational: more than one valid way matches (error flag).
- hit_q  output  1  registered hit.
- hit_idx_q  output  max(1,clog2(WAYS))  registered hit_idx.

Behaviour:
- Equality is a bitwise XNOR-reduce across all TAG_WIDTH bits. A single mismatching bit clears way_match for that way.
- Combinational outputs carry no clock dependency and follow inputs within the same cycle.
- hit is 0 whenever the matching way's stored_valid is 0, including when stored tags are X after cache reset. The AND with valid must dominate, so a 0 valid forces a 0 hit in simulation.
- When stored_valid is all zeros, hit=0, hit_way=0, hit_idx=0 and multi_hit=0, regardless of tags.
- WAYS=1: match == way_match[0], hit_idx is constant 0, and multi_hit is constant 0.
- Registered path, at rising clock:
  - reset=1: hit_q=0, hit_idx_q=0.
  - else if compare_en=1: hit_q<=hit, hit_idx_q<=hit_idx.
  - else: both hold.
- Latency: combinational outputs 0 cycles; hit_q and hit_idx_q 1 cycle after the compare_en cycle.
- Reset is synchronous. Asserting reset mid-lookup clears the registers at the next edge. Combinational outputs are unaffected by reset.
- If compare_en and reset are high together, reset wins.
- Inputs changing while compare_en=0 do not disturb the registered outputs.

Optional Feature:
- Macro TAG_COMPARATOR_STATS_EN.
- Defined: adds outputs hit_count and miss_count (each CNT_WIDTH) and input stats_clear (1).
  - On each rising edge with compare_en=1: hit_count+1 if hit, else miss_count+1.
  - Both counters saturate at all-ones; no wrap.
  - reset or stats_clear zeroes both counters. stats_clear has priority over an increment in the same cycle.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- WAYS=1, valid=1, stored=3'b101, req=3'b101 -> match=1, hit=1. Change req to 3'b100 -> match=0, hit=0 in the same cycle.
- WAYS=1, valid=0, stored=X, req=3'b010 -> hit=0, hit_q stays 0 after a compare_en edge.
- WAYS=4, TAG_WIDTH=3, tags {7,2,5,2}, valid=4'b1110, req=2 -> way_match=4'b1010, hit_way=4'b0010, hit_idx=1, multi_hit=1. Then with valid=4'b0100, req=5 -> hit_way=4'b0100, hit_idx=2, multi_hit=0.
- compare_en=1 with hit=1 -> hit_q=1 next edge. Then compare_en=0 with hit=0 -> hit_q holds 1. Then reset=1 together with compare_en=1 -> hit_q=0 next edge.
- With TAG_COMPARATOR_STATS_EN and CNT_WIDTH=2: apply 5 hit lookups -> hit_count saturates at 3. Apply 2 misses -> miss_count=2. Assert stats_clear in the same cycle as a lookup -> both counters 0.
- Exhaustive sweep, TAG_WIDTH=3, WAYS=1: all 64 (stored, req) pairs with valid=1 -> hit=1 exactly for the 8 equal pairs.

Source files
------------

// File: rtl/tag_comparator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tag_comparator                                               |
// | Description : Cache tag-match block. Compares the request tag against the  |
// |               stored tag of every way, qualifies each match with the way's |
// |               valid bit, and reports hit / hitting way / multi-hit. A      |
// |               registered copy of hit and hit_idx is captured on lookup.    |
// |               Optional hit/miss statistics are enabled by defining the     |
// |               macro TAG_COMPARATOR_STATS_EN.                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tag_comparator #(
  parameter int TAG_WIDTH = 3,
  parameter int WAYS      = 1,
  parameter int CNT_WIDTH = 16,
  localparam int IDX_WIDTH = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      compare_en,
  input  logic [TAG_WIDTH-1:0]      req_tag,
  input  logic [WAYS*TAG_WIDTH-1:0] stored_tags,
  input  logic [WAYS-1:0]           stored_valid,
`ifdef TAG_COMPARATOR_STATS_EN
  input  logic                      stats_clear,
  output logic [CNT_WIDTH-1:0]      hit_count,
  output logic [CNT_WIDTH-1:0]      miss_count,
`endif
  output logic                      match,
  output logic [WAYS-1:0]           way_match,
  output logic                      hit,
  output logic [WAYS-1:0]           hit_way,
  output logic [IDX_WIDTH-1:0]      hit_idx,
  output logic                      multi_hit,
  output logic                      hit_q,
  output logic [IDX_WIDTH-1:0]      hit_idx_q
);

  // Valid-qualified match per way. The AND with a 0 valid bit yields 0 even
  // when the stored tag is still X after a cache reset.
  logic [WAYS-1:0] valid_match;

  // Per-way equality: XNOR every bit and reduce, so any differing bit clears it.
  genvar w;
  generate
    for (w = 0; w < WAYS; w++) begin : g_way
      assign way_match[w] = &(req_tag ~^ stored_tags[w*TAG_WIDTH +: TAG_WIDTH]);
    end
  endgenerate

  assign valid_match = way_match & stored_valid;
  assign match       = |way_match;
  assign hit         = |valid_match;

  generate
    if (WAYS == 1) begin : g_single
      // Only one way: the index can only be zero and two ways cannot collide.
      assign hit_way   = valid_match;
      assign hit_idx   = '0;
      assign multi_hit = 1'b0;
    end else begin : g_multi
      logic [IDX_WIDTH-1:0] idx_enc;

      // Isolate the lowest set bit so the lowest-index way wins.
      assign hit_way   = valid_match & (~valid_match + WAYS'(1));
      // Clearing the lowest set bit leaves something only if two or more ways hit.
      assign multi_hit = |(valid_match & (valid_match - WAYS'(1)));

      // Binary-encode the one-hot hitting way; stays zero on a miss.
      always_comb begin
        idx_enc = '0;
        for (int i = 0; i < WAYS; i++) begin
          if (hit_way[i]) idx_enc = IDX_WIDTH'(i);
        end
      end

      assign hit_idx = idx_enc;
    end
  endgenerate

  // Capture the lookup result on compare_en; hold otherwise; reset dominates.
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
    end else if (compare_en) begin
      hit_q     <= hit;
      hit_idx_q <= hit_idx;
    end
  end

`ifdef TAG_COMPARATOR_STATS_EN
  // Saturating hit/miss counters; clearing beats a same-cycle increment.
  always_ff @(posedge clock) begin
    if (reset || stats_clear) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (compare_en) begin
      if (hit) begin
        if (hit_count != {CNT_WIDTH{1'b1}}) hit_count <= hit_count + CNT_WIDTH'(1);
      end else begin
        if (miss_count != {CNT_WIDTH{1'b1}}) miss_count <= miss_count + CNT_WIDTH'(1);
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tag_comparator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tag_comparator                                            |
// | Description : Self-checking bench for tag_comparator. Two instances: a     |
// |               single-way one and a four-way one, both 3-bit tags and 2-bit |
// |               counters. Statistics checks compile in when                  |
// |               TAG_COMPARATOR_STATS_EN is defined.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_tag_comparator;

  localparam int TW   = 3;
  localparam int CW   = 2;
  localparam int CMAX = 3;

  logic clock = 1'b0;
  logic reset;
  logic stats_clear;

  // single-way instance signals
  logic          en1, valid1, match1, hit1, mh1, hq1;
  logic [TW-1:0] req1, tags1;
  logic [0:0]    wm1, hw1, idx1, idxq1;
  // four-way instance signals
  logic          en4, match4, hit4, mh4, hq4;
  logic [TW-1:0] req4;
  logic [4*TW-1:0] tags4;
  logic [3:0]    valid4, wm4, hw4;
  logic [1:0]    idx4, idxq4;
`ifdef TAG_COMPARATOR_STATS_EN
  logic [CW-1:0] hc1, mc1, hc4, mc4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  tag_comparator #(.TAG_WIDTH(TW), .WAYS(1), .CNT_WIDTH(CW)) dut1 (
    .clock(clock), .reset(reset), .compare_en(en1), .req_tag(req1),
    .stored_tags(tags1), .stored_valid(valid1),
`ifdef TAG_COMPARATOR_STATS_EN
    .stats_clear(stats_clear), .hit_count(hc1), .miss_count(mc1),
`endif
    .match(match1), .way_match(wm1), .hit(hit1), .hit_way(hw1), .hit_idx(idx1),
    .multi_hit(mh1), .hit_q(hq1), .hit_idx_q(idxq1)
  );

  tag_comparator #(.TAG_WIDTH(TW), .WAYS(4), .CNT_WIDTH(CW)) dut4 (
    .clock(clock), .reset(reset), .compare_en(en4), .req_tag(req4),
    .stored_tags(tags4), .stored_valid(valid4),
`ifdef TAG_COMPARATOR_STATS_EN
    .stats_clear(stats_clear), .hit_count(hc4), .miss_count(mc4),
`endif
    .match(match4), .way_match(wm4), .hit(hit4), .hit_way(hw4), .hit_idx(idx4),
    .multi_hit(mh4), .hit_q(hq4), .hit_idx_q(idxq4)
  );

  // Reference lookup for four ways: list the valid matching ways in index order,
  // the first one is the hit, more than one is a multi-hit.
  function automatic void model4(input logic [4*TW-1:0] tags, input logic [3:0] valid,
                                 input logic [TW-1:0] req, output logic [3:0] wm,
                                 output logic m, output logic h, output logic [3:0] hw,
                                 output logic [1:0] idx, output logic mh);
    int hits[$];
    wm = '0; hw = '0; idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (tags[i*TW +: TW] == req) begin
        wm[i] = 1'b1;
        if (valid[i]) hits.push_back(i);
      end
    end
    m  = (wm != 4'b0);
    h  = (hits.size() > 0);
    mh = (hits.size() > 1);
    if (h) begin
      idx = 2'(hits[0]);
      hw[hits[0]] = 1'b1;
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stats_clear = 1'b0;
    en1 = 1'b1; en4 = 1'b1;
    req1 = 3'd5; tags1 = 3'd5; valid1 = 1'b1;
    req4 = 3'd0; tags4 = '0; valid4 = 4'hF;
    tick(); tick();
    checks++;
    if (hq1 !== 1'b0 || idxq1 !== 1'b0) begin
      errors++; $display("FAIL reset_dut1 hit_q=%b hit_idx_q=%b want 0/0", hq1, idxq1);
    end
    checks++;
    if (hq4 !== 1'b0 || idxq4 !== 2'd0) begin
      errors++; $display("FAIL reset_dut4 hit_q=%b hit_idx_q=%0d want 0/0", hq4, idxq4);
    end
`ifdef TAG_COMPARATOR_STATS_EN
    checks++;
    if (hc1 !== 2'd0 || mc1 !== 2'd0 || hc4 !== 2'd0 || mc4 !== 2'd0) begin
      errors++; $display("FAIL reset_counters got %0d %0d %0d %0d want all 0", hc1, mc1, hc4, mc4);
    end
`endif
    reset = 1'b0; en1 = 1'b0; en4 = 1'b0;
  endtask

  task automatic test_single_way();
    valid1 = 1'b1; tags1 = 3'b101; req1 = 3'b101; #1;
    checks++;
    if (match1 !== 1'b1 || hit1 !== 1'b1) begin
      errors++; $display("FAIL single_equal match=%b hit=%b want 1/1", match1, hit1);
    end
    req1 = 3'b100; #1;
    checks++;
    if (match1 !== 1'b0 || hit1 !== 1'b0) begin
      errors++; $display("FAIL single_diff match=%b hit=%b want 0/0", match1, hit1);
    end
    // invalid way with unknown stored tag must never hit
    valid1 = 1'b0; tags1 = 3'bxxx; req1 = 3'b010; #1;
    checks++;
    if (hit1 !== 1'b0 || hw1 !== 1'b0 || idx1 !== 1'b0 || mh1 !== 1'b0) begin
      errors++; $display("FAIL single_x_invalid hit=%b hit_way=%b idx=%b multi=%b want 0", hit1, hw1, idx1, mh1);
    end
    en1 = 1'b1; tick(); en1 = 1'b0;
    checks++;
    if (hq1 !== 1'b0 || idxq1 !== 1'b0) begin
      errors++; $display("FAIL single_x_reg hit_q=%b hit_idx_q=%b want 0/0", hq1, idxq1);
    end
  endtask

  task automatic test_sweep();
    logic [TW-1:0] s, r;
    int nhit = 0;
    valid1 = 1'b1;
    for (int i = 0; i < 64; i++) begin
      s = 3'(i / 8); r = 3'(i % 8);
      tags1 = s; req1 = r; #1;
      if (hit1 === 1'b1) nhit++;
      checks++;
      if (hit1 !== (s == r) || match1 !== (s == r) || wm1 !== (s == r) || hw1 !== (s == r)
          || idx1 !== 1'b0 || mh1 !== 1'b0) begin
        errors++;
        $display("FAIL sweep s=%0d r=%0d hit=%b match=%b wm=%b hw=%b idx=%b multi=%b want hit=%b idx=0 multi=0",
                 s, r, hit1, match1, wm1, hw1, idx1, mh1, (s == r));
      end
    end
    checks++;
    if (nhit != 8) begin
      errors++; $display("FAIL sweep_hit_total got %0d want 8", nhit);
    end
  endtask

  task automatic test_multi_way();
    tags4 = {3'd2, 3'd5, 3'd2, 3'd7};
    valid4 = 4'b1110; req4 = 3'd2; #1;
    checks++;
    if (wm4 !== 4'b1010 || hw4 !== 4'b0010 || idx4 !== 2'd1 || mh4 !== 1'b1 || hit4 !== 1'b1) begin
      errors++; $display("FAIL multi_dup wm=%b hw=%b idx=%0d multi=%b hit=%b want 1010/0010/1/1/1",
                         wm4, hw4, idx4, mh4, hit4);
    end
    valid4 = 4'b0100; req4 = 3'd5; #1;
    checks++;
    if (hw4 !== 4'b0100 || idx4 !== 2'd2 || mh4 !== 1'b0 || hit4 !== 1'b1) begin
      errors++; $display("FAIL multi_single hw=%b idx=%0d multi=%b hit=%b want 0100/2/0/1", hw4, idx4, mh4, hit4);
    end
    valid4 = 4'b0000; req4 = 3'd2; #1;
    checks++;
    if (hit4 !== 1'b0 || hw4 !== 4'b0 || idx4 !== 2'd0 || mh4 !== 1'b0 || match4 !== 1'b1) begin
      errors++; $display("FAIL multi_novalid hit=%b hw=%b idx=%0d multi=%b match=%b want 0/0/0/0/1",
                         hit4, hw4, idx4, mh4, match4);
    end
  endtask

  task automatic test_registered();
    tags4 = {3'd2, 3'd5, 3'd2, 3'd7}; valid4 = 4'b0100; req4 = 3'd5;
    en4 = 1'b1; tick();
    checks++;
    if (hq4 !== 1'b1 || idxq4 !== 2'd2) begin
      errors++; $display("FAIL reg_capture hit_q=%b idx_q=%0d want 1/2", hq4, idxq4);
    end
    en4 = 1'b0; req4 = 3'd0; tick();
    checks++;
    if (hq4 !== 1'b1 || idxq4 !== 2'd2) begin
      errors++; $display("FAIL reg_hold hit_q=%b idx_q=%0d want 1/2", hq4, idxq4);
    end
    req4 = 3'd5; en4 = 1'b1; reset = 1'b1; tick();
    checks++;
    if (hq4 !== 1'b0 || idxq4 !== 2'd0) begin
      errors++; $display("FAIL reg_reset_wins hit_q=%b idx_q=%0d want 0/0", hq4, idxq4);
    end
    reset = 1'b0; en4 = 1'b0;
  endtask

`ifdef TAG_COMPARATOR_STATS_EN
  task automatic test_stats();
    stats_clear = 1'b1; en1 = 1'b0; tick(); stats_clear = 1'b0;
    valid1 = 1'b1; tags1 = 3'd5; req1 = 3'd5; en1 = 1'b1;
    repeat (5) tick();
    checks++;
    if (hc1 !== 2'd3 || mc1 !== 2'd0) begin
      errors++; $display("FAIL stats_saturate hit_count=%0d miss_count=%0d want 3/0", hc1, mc1);
    end
    req1 = 3'd4;
    repeat (2) tick();
    checks++;
    if (hc1 !== 2'd3 || mc1 !== 2'd2) begin
      errors++; $display("FAIL stats_miss hit_count=%0d miss_count=%0d want 3/2", hc1, mc1);
    end
    stats_clear = 1'b1; tick(); stats_clear = 1'b0; en1 = 1'b0;
    checks++;
    if (hc1 !== 2'd0 || mc1 !== 2'd0) begin
      errors++; $display("FAIL stats_clear_priority hit_count=%0d miss_count=%0d want 0/0", hc1, mc1);
    end
  endtask
`endif

  task automatic test_random();
    logic [3:0] e_wm, e_hw;
    logic       e_m, e_h, e_mh, m_hq;
    logic [1:0] e_idx, m_idxq;
    int         m_hc, m_mc;
    reset = 1'b1; stats_clear = 1'b0; en4 = 1'b0; tick(); reset = 1'b0;
    m_hq = 1'b0; m_idxq = 2'd0; m_hc = 0; m_mc = 0;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 4; i++) tags4[i*TW +: TW] = 3'($urandom_range(0, 3));
      valid4      = 4'($urandom);
      req4        = 3'($urandom_range(0, 4));
      en4         = 1'($urandom);
      reset       = ($urandom_range(0, 19) == 0);
      stats_clear = ($urandom_range(0, 19) == 0);
      #1;
      model4(tags4, valid4, req4, e_wm, e_m, e_h, e_hw, e_idx, e_mh);
      checks++;
      if (wm4 !== e_wm || match4 !== e_m || hit4 !== e_h || hw4 !== e_hw || idx4 !== e_idx || mh4 !== e_mh) begin
        errors++;
        $display("FAIL rand_comb n=%0d wm=%b m=%b h=%b hw=%b idx=%0d mh=%b want %b/%b/%b/%b/%0d/%b",
                 n, wm4, match4, hit4, hw4, idx4, mh4, e_wm, e_m, e_h, e_hw, e_idx, e_mh);
      end
      if (reset) begin
        m_hq = 1'b0; m_idxq = 2'd0;
      end else if (en4) begin
        m_hq = e_h; m_idxq = e_idx;
      end
      if (reset || stats_clear) begin
        m_hc = 0; m_mc = 0;
      end else if (en4) begin
        if (e_h) m_hc = (m_hc < CMAX) ? m_hc + 1 : CMAX;
        else     m_mc = (m_mc < CMAX) ? m_mc + 1 : CMAX;
      end
      tick();
      checks++;
      if (hq4 !== m_hq || idxq4 !== m_idxq) begin
        errors++; $display("FAIL rand_reg n=%0d hit_q=%b idx_q=%0d want %b/%0d", n, hq4, idxq4, m_hq, m_idxq);
      end
`ifdef TAG_COMPARATOR_STATS_EN
      checks++;
      if (hc4 !== 2'(m_hc) || mc4 !== 2'(m_mc)) begin
        errors++; $display("FAIL rand_stats n=%0d hit_count=%0d miss_count=%0d want %0d/%0d", n, hc4, mc4, m_hc, m_mc);
      end
`endif
    end
    reset = 1'b0; stats_clear = 1'b0; en4 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_way();
    test_sweep();
    test_multi_way();
    test_registered();
`ifdef TAG_COMPARATOR_STATS_EN
    test_stats();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
